// File: rtl/des_perm_pipe_if.sv
// Handshake bundle for the DES permutation engine: input block side and
// result side grouped together so the bench and the engine share one view.
//
// Valid/ready: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and its payload stable until that edge;
// a sink may raise or drop ready freely, and ready may depend combinationally
// on valid or on downstream ready, but valid never depends on ready.
interface des_perm_pipe_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    // Producer of blocks / consumer of results.
    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The permutation engine.
    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/des_perm_pipe.sv
// Elastic pipelined DES IP / FP (IP^-1) bit-permutation engine.
// The permutation is pure wiring in front of stage 0; the remaining stages
// only carry data, tag and valid. Bubbles collapse, so an empty stage never
// stalls the stages behind it. A 16-bit counter tallies output handshakes.
module des_perm_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    des_perm_pipe_if.slave     bus,
    output logic               busy,
    output logic [15:0]        blk_count,
    input  logic               cnt_clr
);
    localparam int LAST = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] valid_q;
    logic [63:0]            data_q [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] adv;
    logic                   adv_chain;
    logic [63:0]            perm;
    logic                   out_hs;
    logic [15:0]            cnt_q;
    logic [15:0]            cnt_d;

    // FP source bit for output bit i (i = 8r + c): (c even ? 4c+39 : 4c+3) - r.
    // IP is the exact inverse, obtained by scattering instead of gathering.
    function automatic logic [5:0] src_idx(input logic [5:0] i);
        logic [2:0] r;
        logic [2:0] c;
        logic [5:0] base;
        r    = i[5:3];
        c    = i[2:0];
        base = c[0] ? (6'({c, 2'b00}) + 6'd3) : (6'({c, 2'b00}) + 6'd39);
        return base - {3'b000, r};
    endfunction

    // Permutation network: FP gathers, IP scatters through the same index map.
    always_comb begin
        perm = '0;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_inv) begin
                perm[6'(i)] = bus.in_data[src_idx(6'(i))];
            end else begin
                perm[src_idx(6'(i))] = bus.in_data[6'(i)];
            end
        end
    end

    // Advance chain: a stage moves if it is empty or everything ahead of it moves.
    always_comb begin
        adv       = '0;
        adv_chain = !valid_q[LAST] || bus.out_ready;
        adv[LAST] = adv_chain;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv_chain = !valid_q[k] || adv_chain;
            adv[k]    = adv_chain;
        end
    end

    assign bus.in_ready  = adv[0] && !rst;
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.out_tag   = tag_q[LAST];
    assign busy          = |valid_q;
    assign out_hs        = valid_q[LAST] && bus.out_ready;
    assign blk_count     = cnt_q;

    // Stage registers: payload only loads when the stage advances with a valid source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    data_q[0] <= perm;
                    tag_q[0]  <= bus.in_tag;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                    end
                end
            end
        end
    end

    // Completed-block counter next state: clear wins over a coincident handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Completed-block counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: directed literal vectors, random IP/FP round trips
// with back-pressure, stall, mid-flight reset and counter wrap / clear.
module tb_des_perm_pipe;
    localparam int P  = 2;
    localparam int TW = 4;
    localparam int W  = 64 + TW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        busy;
    logic [15:0] blk_count;

    des_perm_pipe_if #(.TAG_W(TW)) bus ();

    des_perm_pipe #(.PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .blk_count (blk_count),
        .cnt_clr   (cnt_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // ---------------- reference model ----------------
    function automatic int src_of(input int i);
        int r;
        int c;
        r = i / 8;
        c = i % 8;
        return ((c % 2 == 0) ? (4 * c + 39) : (4 * c + 3)) - r;
    endfunction

    // FP: output bit i is taken from input bit src_of(i).
    function automatic logic [63:0] fp_m(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[i] = x[src_of(i)];
        return y;
    endfunction

    // IP: undo FP by locating, for each output bit, the FP position that read it.
    function automatic logic [63:0] ip_m(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++)
            for (int i = 0; i < 64; i++)
                if (src_of(i) == j) y[j] = x[i];
        return y;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] exp_q[$];
    int           inflight = 0;
    logic [15:0]  cnt_m = '0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held = '0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         in_hs;
        logic         out_hs;
        if (rst) begin
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_blk_count", blk_count, 0);
            exp_q.delete();
            inflight   = 0;
            cnt_m      = '0;
            stall_prev = 1'b0;
        end else begin
            in_hs  = bus.in_valid && bus.in_ready;
            out_hs = bus.out_valid && bus.out_ready;
            check("in_ready", bus.in_ready, (inflight < P) || bus.out_ready);
            check("busy", busy, inflight != 0);
            check("blk_count", blk_count, cnt_m);
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_hold", {bus.out_tag, bus.out_data}, held);
            end
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected no block", {bus.out_tag, bus.out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("out_block", {bus.out_tag, bus.out_data}, e);
                end
                if (inflight > 0) inflight--;
            end
            if (in_hs) begin
                exp_q.push_back({bus.in_tag, bus.in_inv ? fp_m(bus.in_data) : ip_m(bus.in_data)});
                inflight++;
            end
            if (cnt_clr) cnt_m = '0;
            else if (out_hs) cnt_m = cnt_m + 16'd1;
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = {bus.out_tag, bus.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [63:0] d, input logic inv, input logic [TW-1:0] tag);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        bus.in_tag   = tag;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic expect_lit(input string nm, input logic [63:0] d, input logic [TW-1:0] tg);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1;
                check({nm, "_data"}, bus.out_data, d);
                check({nm, "_tag"}, bus.out_tag, tg);
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_now({nm, "_wait"});
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    // ---------------- directed vectors ----------------
    logic [63:0]   dv_in  [6];
    logic          dv_inv [6];
    logic [63:0]   dv_exp [6];
    bit            stim_done = 1'b0;

    initial begin
        dv_in[0] = 64'h0000000000000001; dv_inv[0] = 1'b0; dv_exp[0] = 64'h0000008000000000;
        dv_in[1] = 64'h0000000000000001; dv_inv[1] = 1'b1; dv_exp[1] = 64'h0200000000000000;
        dv_in[2] = 64'h0000008000000000; dv_inv[2] = 1'b1; dv_exp[2] = 64'h0000000000000001;
        dv_in[3] = 64'h0200000000000000; dv_inv[3] = 1'b0; dv_exp[3] = 64'h0000000000000001;
        dv_in[4] = 64'h8000000000000000; dv_inv[4] = 1'b1; dv_exp[4] = 64'h0000000000000040;
        dv_in[5] = 64'h8000000000000000; dv_inv[5] = 1'b0; dv_exp[5] = 64'h0000000001000000;
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        bit hs;
        logic [63:0] x;
        logic [TW-1:0] tg;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_data", bus.out_data, 0);
        check("post_rst_out_tag", bus.out_tag, 0);
        @(posedge clk);
        #1;

        // IP of bit 0 with latency check
        send(64'h1, 1'b0, 4'd3);
        for (int j = 0; j < P - 1; j++) begin
            @(negedge clk);
            check("latency_early", bus.out_valid, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 64'h0000008000000000);
        check("t1_tag", bus.out_tag, 3);
        @(posedge clk);
        #1;

        // Directed literal vectors
        for (int v = 0; v < 6; v++) begin
            send(dv_in[v], dv_inv[v], 4'(v + 5));
            expect_lit("dv", dv_exp[v], 4'(v + 5));
        end

        // Random IP -> FP round trips with random back-pressure
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    x  = {$urandom, $urandom};
                    tg = 4'($urandom_range(0, 15));
                    check("model_roundtrip", fp_m(ip_m(x)), x);
                    send(x, 1'b0, tg);
                    send(ip_m(x), 1'b1, tg + 4'd1);
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Stall: out_ready low for 10 cycles while streaming
        bus.out_ready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0123456789ABCDEF;
        bus.in_inv   = 1'b0;
        bus.in_tag   = 4'd9;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hs = bus.in_ready;
            if (hs) acc++;
            @(posedge clk);
            #1;
            if (hs) begin
                bus.in_data = bus.in_data + 64'h1111;
                bus.in_inv  = ~bus.in_inv;
                bus.in_tag  = bus.in_tag + 4'd1;
            end
        end
        bus.in_valid = 1'b0;
        check("stall_accepted", acc, P);
        @(negedge clk);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset with blocks in flight
        bus.out_ready = 1'b0;
        send(64'hDEADBEEF00C0FFEE, 1'b0, 4'd1);
        send(64'h0F0F0F0F0F0F0F0F, 1'b1, 4'd2);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_count", blk_count, 0);
        check("rst_async_data", bus.out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Counter wrap via handshakes, then clear coincident with a handshake
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        for (int n = 0; n < 65535; n++) send({$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'(n));
        drain();
        @(negedge clk);
        check("cnt_ffff", blk_count, 16'hFFFF);
        @(posedge clk);
        #1;
        send(64'h5, 1'b0, 4'd0);
        drain();
        @(negedge clk);
        check("cnt_wrap", blk_count, 16'h0000);
        @(posedge clk);
        #1;
        send(64'h6, 1'b1, 4'd1);
        send(64'h7, 1'b0, 4'd2);
        drain();
        bus.out_ready = 1'b0;
        send(64'h8, 1'b1, 4'd3);
        for (int t = 0; t < 20 && !bus.out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("clr_setup_valid", bus.out_valid, 1);
        cnt_clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", blk_count, 16'h0000);
        check("clr_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
